morse_decoder: RTL



---
 rtl/morse_pkg.sv | 73 +++++++
 rtl/morse_tick_gen.sv | 34 +++
 rtl/morse_decoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// morse_pkg
// Definitions shared by the Morse letter encoder and decoder.
// Holds the letter indices A..H, element encodings, run-length thresholds,
// the decoder state enum and the A..H decode table with a lookup helper.
// No ports; import with "import morse_pkg::*;".

package morse_pkg;

    // Letter indices as reported on the decoder letter output
    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;

    // Element encodings as shifted into the pattern register
    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

    // Run-length thresholds in unit times
    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
    // A two-unit space is neither an intra-letter gap nor a letter end
    localparam logic [2:0] BAD_GAP_UNITS    = 3'd2;
    localparam logic [2:0] RUN_MAX          = 3'd7;

    // Width of the table patterns (longest A..H code has four elements)
    localparam int CODE_BITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    // Decode table: element count and pattern, LSB = last element sent
    localparam logic [2:0] LEN_A = 3'd2;  localparam logic [3:0] PAT_A = 4'b0001;
    localparam logic [2:0] LEN_B = 3'd4;  localparam logic [3:0] PAT_B = 4'b1000;
    localparam logic [2:0] LEN_C = 3'd4;  localparam logic [3:0] PAT_C = 4'b1010;
    localparam logic [2:0] LEN_D = 3'd3;  localparam logic [3:0] PAT_D = 4'b0100;
    localparam logic [2:0] LEN_E = 3'd1;  localparam logic [3:0] PAT_E = 4'b0000;
    localparam logic [2:0] LEN_F = 3'd4;  localparam logic [3:0] PAT_F = 4'b0010;
    localparam logic [2:0] LEN_G = 3'd3;  localparam logic [3:0] PAT_G = 4'b0110;
    localparam logic [2:0] LEN_H = 3'd4;  localparam logic [3:0] PAT_H = 4'b0000;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } decode_t;

    // Matches a completed element sequence against the table. Length takes
    // part in the match so that E (1:0) and H (4:0000) stay distinct.
    function automatic decode_t decode_lookup(input logic [2:0] len,
                                              input logic [CODE_BITS-1:0] pattern);
        decode_t result;
        result = '{hit: 1'b1, idx: LTR_A};
        if      (len == LEN_A && pattern == PAT_A) result.idx = LTR_A;
        else if (len == LEN_B && pattern == PAT_B) result.idx = LTR_B;
        else if (len == LEN_C && pattern == PAT_C) result.idx = LTR_C;
        else if (len == LEN_D && pattern == PAT_D) result.idx = LTR_D;
        else if (len == LEN_E && pattern == PAT_E) result.idx = LTR_E;
        else if (len == LEN_F && pattern == PAT_F) result.idx = LTR_F;
        else if (len == LEN_G && pattern == PAT_G) result.idx = LTR_G;
        else if (len == LEN_H && pattern == PAT_H) result.idx = LTR_H;
        else                                       result.hit = 1'b0;
        return result;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// morse_tick_gen
// Unit-time divider: pulses tick for one clock once every DIV clocks.
// Ports:
//   clk   - system clock, all state on posedge
//   reset - synchronous active-high, returns the count to 0
//   tick  - one-cycle unit-time strobe

module morse_tick_gen #(
    parameter int DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Free-running count that wraps after LAST; the strobe marks the wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder
// Decodes the serial Morse stream produced by the Morse letter encoder.
// Mark/space run lengths are measured in unit-time ticks, classified into
// dots, dashes and gaps, and each letter's elements are collected and
// looked up in the A..H table when a three-unit space ends the letter.
// Optional feature: define MORSE_DEC_TICKGEN_EN to generate the unit tick
// internally from CLOCK_50 (TICK_DIV cycles per unit); the tick port is then
// ignored. Without it the tick port drives sampling directly.
// Ports:
//   CLOCK_50     - system clock, all state on posedge
//   reset        - synchronous active-high, clears all state and outputs
//   tick         - one-cycle unit-time strobe, morse_in sampled only then
//   morse_in     - serial Morse stream, 1 = mark, 0 = space
//   letter       - last decoded letter index 0=A..7=H, held between letters
//   letter_valid - one-cycle pulse, letter updated this cycle
//   letter_error - one-cycle pulse, letter ended malformed or unknown
//   busy         - high whenever a letter is in progress

module morse_decoder
    import morse_pkg::*;
#(
    parameter int MAX_ELEMS = 4,
    parameter int TICK_DIV  = 25000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick,
    input  logic       morse_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       letter_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(MAX_ELEMS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ELEMS);

    logic sample;

`ifdef MORSE_DEC_TICKGEN_EN
    logic gen_tick;
    logic unused_tick;

    morse_tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (CLOCK_50),
        .reset(reset),
        .tick (gen_tick)
    );

    assign sample      = gen_tick;
    assign unused_tick = tick;
`else
    logic [31:0] unused_tick_div;

    assign sample          = tick;
    assign unused_tick_div = 32'(TICK_DIV);
`endif

    state_t                 state, state_next;
    logic [2:0]             run, run_next;
    logic [CNT_W-1:0]       elem_cnt, elem_cnt_next;
    logic [MAX_ELEMS-1:0]   pattern, pattern_next;
    logic                   bad, bad_next;
    logic [2:0]             letter_next;
    logic                   valid_next, error_next;
    logic                   elem;
    decode_t                lookup;

    // State register; reset returns to IDLE regardless of tick
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers; reset discards any partial letter
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            run          <= '0;
            elem_cnt     <= '0;
            pattern      <= '0;
            bad          <= 1'b0;
            letter       <= LTR_A;
            letter_valid <= 1'b0;
            letter_error <= 1'b0;
        end else begin
            run          <= run_next;
            elem_cnt     <= elem_cnt_next;
            pattern      <= pattern_next;
            bad          <= bad_next;
            letter       <= letter_next;
            letter_valid <= valid_next;
            letter_error <= error_next;
        end
    end

    // The element just finished: only a three-unit mark counts as a dash;
    // odd lengths are flagged bad separately so the shifted value is moot.
    assign elem   = (run == DASH_UNITS) ? ELEM_DASH : ELEM_DOT;
    assign lookup = decode_lookup(3'(elem_cnt), CODE_BITS'(pattern));

    // Next-state and datapath logic. Without a tick everything holds and
    // the valid/error pulses fall back to 0.
    always_comb begin
        state_next    = state;
        run_next      = run;
        elem_cnt_next = elem_cnt;
        pattern_next  = pattern;
        bad_next      = bad;
        letter_next   = letter;
        valid_next    = 1'b0;
        error_next    = 1'b0;

        if (sample) begin
            case (state)
                IDLE: begin
                    if (morse_in) begin
                        run_next   = 3'd1;
                        state_next = MARK;
                    end
                end

                MARK: begin
                    if (morse_in) begin
                        if (run != RUN_MAX) begin
                            run_next = run + 3'd1;
                        end
                    end else begin
                        if (run != DOT_UNITS && run != DASH_UNITS) begin
                            bad_next = 1'b1;
                        end
                        // A letter longer than the table allows is bad and
                        // must not shift older elements out of the pattern
                        if (elem_cnt == CNT_MAX) begin
                            bad_next = 1'b1;
                        end else begin
                            pattern_next  = {pattern[MAX_ELEMS-2:0], elem};
                            elem_cnt_next = elem_cnt + 1'b1;
                        end
                        run_next   = 3'd1;
                        state_next = SPACE;
                    end
                end

                SPACE: begin
                    if (morse_in) begin
                        if (run == BAD_GAP_UNITS) begin
                            bad_next = 1'b1;
                        end
                        run_next   = 3'd1;
                        state_next = MARK;
                    end else if (run + 3'd1 == LETTER_GAP_UNITS) begin
                        if (!bad && lookup.hit) begin
                            letter_next = lookup.idx;
                            valid_next  = 1'b1;
                        end else begin
                            error_next  = 1'b1;
                        end
                        pattern_next  = '0;
                        elem_cnt_next = '0;
                        run_next      = '0;
                        bad_next      = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        run_next = run + 3'd1;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output decode from the state register
    always_comb begin
        busy = (state != IDLE);
    end

endmodule
